// File: rtl/eviction_fifo.sv
// Write-back buffer for dirty victim lines: drains oldest-first to memory,
// merges repeat evictions of a non-head line, and offers a combinational lookup.
module eviction_fifo #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data
);

    // Memory handshake: mem_write is the valid, mem_resp is the accept. The head
    // entry is offered while mem_write is high and does not change until the
    // edge at which mem_resp is sampled; mem_resp with mem_write low is ignored.

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic                  lk_hit, co_hit;
    logic [PW-1:0]         lk_idx, co_idx, lk_age, co_age;
    logic                  do_pop, need_append, do_append;

    // Age of slot i relative to head: 0 is oldest, count-1 is youngest.
    function automatic logic [PW-1:0] slot_age(input int i, input logic [PW-1:0] head);
        return PW'(i) - head;
    endfunction

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        lk_age = '0;
        co_hit = 1'b0;
        co_idx = '0;
        co_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(slot_age(i, head_q)) < count_q) begin
                if (addr_q[i] == lookup_addr && (!lk_hit || slot_age(i, head_q) > lk_age)) begin
                    lk_hit = 1'b1;
                    lk_idx = PW'(i);
                    lk_age = slot_age(i, head_q);
                end
                // Head is excluded so the line on the memory bus never changes.
                if (slot_age(i, head_q) != '0 && addr_q[i] == push_addr &&
                    (!co_hit || slot_age(i, head_q) > co_age)) begin
                    co_hit = 1'b1;
                    co_idx = PW'(i);
                    co_age = slot_age(i, head_q);
                end
            end
        end
    end

    always_comb begin
        do_pop      = mem_resp && (count_q != '0);
        need_append = push && !co_hit;
        do_append   = need_append && ((count_q != CW'(DEPTH)) || mem_resp);

        addr_d = addr_q;
        data_d = data_q;
        if (push && co_hit) begin
            data_d[co_idx] = push_data;
        end
        if (do_append) begin
            addr_d[tail_q] = push_addr;
            data_d[tail_q] = push_data;
        end
        head_d     = head_q + PW'(do_pop);
        tail_d     = tail_q + PW'(do_append);
        count_d    = count_q + CW'(do_append) - CW'(do_pop);
        overflow_d = overflow_q | (need_append & ~do_append);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign overflow    = overflow_q;
    assign mem_write   = !empty;
    assign mem_address = empty ? '0 : addr_q[head_q];
    assign mem_wdata   = empty ? '0 : data_q[head_q];
    assign lookup_hit  = lk_hit;
    assign lookup_data = lk_hit ? data_q[lk_idx] : '0;

endmodule

// File: tb/tb_eviction_fifo.sv
// Randomised and directed bench for eviction_fifo against a queue-based model.
module tb_eviction_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int DW    = 128;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic [DW-1:0] push_data = '0;
    logic          full, empty, overflow, mem_write, lookup_hit;
    logic [CW-1:0] count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata, lookup_data;
    logic          mem_resp = 1'b0;
    logic [AW-1:0] lookup_addr = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a queue of lines, oldest at index 0.
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_ovf = 1'b0;

    eviction_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr),
        .push_data(push_data), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] a);
        for (int i = 0; i < exp_q.size(); i++) if (exp_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i] == a) return exp_d[i];
        return '0;
    endfunction

    task automatic model_step(input logic p, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic r);
        int n = exp_q.size();
        int ci = -1;
        if (p) for (int i = n - 1; i >= 1; i--) if (ci < 0 && exp_q[i] == a) ci = i;
        if (ci >= 0) exp_d[ci] = d;
        if (r && n > 0) begin
            void'(exp_q.pop_front());
            void'(exp_d.pop_front());
        end
        if (p && ci < 0) begin
            if (n < DEPTH || r) begin
                exp_q.push_back(a);
                exp_d.push_back(d);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic p, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic r);
        push = p; push_addr = a; push_data = d; mem_resp = r;
        @(posedge clk);
        model_step(p, a, d, r);
        #1;
        push = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete(); exp_d.delete(); exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", empty); end
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if (mem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", full); end
        tests_run++; if (mem_address !== '0 || mem_wdata !== '0) begin tests_failed++; $display("FAIL reset_mem_bus got %h/%h exp 0", mem_address, mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            lookup_addr = (i == 0) ? 12'h000 : AW'($urandom_range(0, 4095));
            #1;
            tests_run++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin tests_failed++; $display("FAIL reset_lookup addr %h got %b/%h exp 0", lookup_addr, lookup_hit, lookup_data); end
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_data();
            drive(1'b1, AW'(12'h010 * (i + 1)), d[i], 1'b0);
        end
        tests_run++; if (full !== 1'b1 || count !== CW'(4)) begin tests_failed++; $display("FAIL fill_full got full=%b count=%0d exp 1/4", full, count); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem_write !== 1'b1 || mem_address !== AW'(12'h010 * (i + 1)) || mem_wdata !== d[i]) begin
                tests_failed++;
                $display("FAIL drain_head%0d got %b/%h exp 1/%h", i, mem_write, mem_address, 12'h010 * (i + 1));
            end
            drive(1'b0, '0, '0, 1'b1);
        end
        tests_run++; if (empty !== 1'b1 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b/%b exp 1/0", empty, mem_write); end
    endtask

    task automatic test_coalesce();
        logic [DW-1:0] a, b, e;
        a = rand_data(); b = rand_data(); e = rand_data();
        do_reset();
        drive(1'b1, 12'h010, a, 1'b0);
        drive(1'b1, 12'h020, b, 1'b0);
        drive(1'b1, 12'h020, e, 1'b0);
        tests_run++; if (count !== CW'(2)) begin tests_failed++; $display("FAIL coalesce_count got %0d exp 2", count); end
        lookup_addr = 12'h020; #1;
        tests_run++; if (lookup_hit !== 1'b1 || lookup_data !== e) begin tests_failed++; $display("FAIL coalesce_lookup got %b/%h exp 1/%h", lookup_hit, lookup_data, e); end
        tests_run++; if (mem_address !== 12'h010 || mem_wdata !== a) begin tests_failed++; $display("FAIL coalesce_head0 got %h exp 010", mem_address); end
        drive(1'b0, '0, '0, 1'b1);
        tests_run++; if (mem_address !== 12'h020 || mem_wdata !== e) begin tests_failed++; $display("FAIL coalesce_head1 got %h/%h exp 020/%h", mem_address, mem_wdata, e); end
    endtask

    task automatic test_head_match();
        logic [DW-1:0] a, f;
        a = rand_data(); f = rand_data();
        do_reset();
        drive(1'b1, 12'h010, a, 1'b0);
        drive(1'b1, 12'h010, f, 1'b0);
        tests_run++; if (count !== CW'(2)) begin tests_failed++; $display("FAIL headmatch_count got %0d exp 2", count); end
        lookup_addr = 12'h010; #1;
        tests_run++; if (lookup_data !== f) begin tests_failed++; $display("FAIL headmatch_lookup got %h exp %h", lookup_data, f); end
        tests_run++; if (mem_address !== 12'h010 || mem_wdata !== a) begin tests_failed++; $display("FAIL headmatch_head0 got %h/%h exp 010/%h", mem_address, mem_wdata, a); end
        drive(1'b0, '0, '0, 1'b1);
        tests_run++; if (mem_address !== 12'h010 || mem_wdata !== f) begin tests_failed++; $display("FAIL headmatch_head1 got %h/%h exp 010/%h", mem_address, mem_wdata, f); end
    endtask

    task automatic test_full_boundary();
        logic [DW-1:0] g;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(12'h010 * (i + 1)), rand_data(), 1'b0);
        drive(1'b1, 12'h050, rand_data(), 1'b1);
        tests_run++; if (count !== CW'(4) || overflow !== 1'b0) begin tests_failed++; $display("FAIL full_pushpop got count=%0d ovf=%b exp 4/0", count, overflow); end
        tests_run++; if (mem_address !== 12'h020) begin tests_failed++; $display("FAIL full_pushpop_head got %h exp 020", mem_address); end
        drive(1'b1, 12'h060, rand_data(), 1'b0);
        lookup_addr = 12'h060; #1;
        tests_run++; if (overflow !== 1'b1 || count !== CW'(4) || lookup_hit !== 1'b0) begin tests_failed++; $display("FAIL full_drop got ovf=%b count=%0d hit=%b exp 1/4/0", overflow, count, lookup_hit); end
        g = rand_data();
        drive(1'b1, 12'h030, g, 1'b0);
        lookup_addr = 12'h030; #1;
        tests_run++; if (count !== CW'(4) || lookup_data !== g || overflow !== 1'b1) begin tests_failed++; $display("FAIL full_coalesce got count=%0d data=%h exp 4/%h", count, lookup_data, g); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem_address !== exp_q[0] || mem_wdata !== exp_d[0]) begin tests_failed++; $display("FAIL full_order%0d got %h exp %h", i, mem_address, exp_q[0]); end
            drive(1'b0, '0, '0, 1'b1);
        end
        tests_run++; if (overflow !== 1'b1 || empty !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky got ovf=%b empty=%b exp 1/1", overflow, empty); end
    endtask

    task automatic test_random();
        logic [AW-1:0] la;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            drive(1'($urandom_range(0, 99) < 65), AW'(12'h010 * $urandom_range(1, 5)),
                  rand_data(), 1'($urandom_range(0, 99) < 45));
            tests_run++;
            if (count !== CW'(exp_q.size()) || overflow !== exp_ovf ||
                mem_write !== (exp_q.size() != 0) ||
                mem_address !== ((exp_q.size() != 0) ? exp_q[0] : '0) ||
                mem_wdata !== ((exp_q.size() != 0) ? exp_d[0] : '0)) begin
                tests_failed++;
                $display("FAIL random_state cyc %0d got count=%0d ovf=%b addr=%h exp count=%0d ovf=%b", c, count, overflow, mem_address, exp_q.size(), exp_ovf);
            end
            la = AW'(12'h010 * $urandom_range(1, 5));
            lookup_addr = la; #1;
            tests_run++;
            if (lookup_hit !== model_hit(la) || lookup_data !== model_data(la)) begin
                tests_failed++;
                $display("FAIL random_lookup cyc %0d addr %h got %b/%h exp %b/%h", c, la, lookup_hit, lookup_data, model_hit(la), model_data(la));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(12'h100 + i), rand_data(), 1'b0);
        tests_run++; if (count !== CW'(3)) begin tests_failed++; $display("FAIL midreset_pre got %0d exp 3", count); end
        rst_n = 1'b0; mem_resp = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_resp = 1'b0;
        exp_q.delete(); exp_d.delete(); exp_ovf = 1'b0;
        lookup_addr = 12'h100; #1;
        tests_run++; if (count !== '0 || mem_write !== 1'b0 || lookup_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset got count=%0d mw=%b hit=%b exp 0/0/0", count, mem_write, lookup_hit); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_coalesce();
        test_head_match();
        test_full_boundary();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
